// File: rtl/irq_stamp.sv
// Per-vector interrupt arrival time stamps with valid/overrun tracking.
// Stamps and status are exposed as read-only CSRs; reading a stamp consumes it.
module irq_stamp #(
    parameter int unsigned VecSize    = 8,
    parameter int unsigned TimerWidth = 16,
    parameter logic [11:0] CsrBase    = 12'hB40
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [TimerWidth-1:0] i_mono_timer,
    input  logic [VecSize-1:0]    i_pend,
    input  logic                  i_csr_enable,
    input  logic [11:0]           i_csr_addr,
    output logic [31:0]           o_csr_out,
    output logic [VecSize-1:0]    o_stamp_valid
);

    logic [TimerWidth-1:0] r_stamp [VecSize];
    logic [VecSize-1:0]    r_valid;
    logic [VecSize-1:0]    r_overrun;
    logic [VecSize-1:0]    r_pend_q;

    logic [VecSize-1:0]    w_rise;
    logic [VecSize-1:0]    w_rd_hit;
    logic [11:0]           w_offset;
    logic [31:0]           w_status;

    assign w_rise        = i_pend & ~r_pend_q;
    // Modulo-4096 offset keeps decode correct even if the window sits near the top.
    assign w_offset      = i_csr_addr - CsrBase;
    assign o_stamp_valid = r_valid;

    always_comb begin
        w_rd_hit = '0;
        for (int k = 0; k < VecSize; k++) begin
            w_rd_hit[k] = i_csr_enable && (w_offset == 12'(k));
        end
    end

    always_comb begin
        w_status = '0;
        w_status[VecSize-1:0]     = r_valid;
        w_status[16+VecSize-1:16] = r_overrun;
    end

    always_comb begin
        o_csr_out = '0;
        for (int k = 0; k < VecSize; k++) begin
            if (w_offset == 12'(k)) begin
                o_csr_out[TimerWidth-1:0] = r_stamp[k];
                o_csr_out[31]             = r_overrun[k];
            end
        end
        if (w_offset == 12'(VecSize)) begin
            o_csr_out = w_status;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_q  <= '0;
            r_valid   <= '0;
            r_overrun <= '0;
            for (int k = 0; k < VecSize; k++) begin
                r_stamp[k] <= '0;
            end
        end else begin
            r_pend_q <= i_pend;
            for (int k = 0; k < VecSize; k++) begin
                if (w_rise[k]) begin
                    // A same-cycle read consumed the old stamp, so it cannot be overrun.
                    r_stamp[k]   <= i_mono_timer;
                    r_valid[k]   <= 1'b1;
                    r_overrun[k] <= r_valid[k] & ~w_rd_hit[k];
                end else if (w_rd_hit[k]) begin
                    r_valid[k]   <= 1'b0;
                    r_overrun[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_irq_stamp.sv
// Directed-vector bench for irq_stamp with hand-computed expected CSR values.
module tb_irq_stamp;

    localparam int unsigned VecSize    = 8;
    localparam int unsigned TimerWidth = 16;
    localparam logic [11:0] CsrBase    = 12'hB40;

    logic                  clk;
    logic                  reset;
    logic [TimerWidth-1:0] mono_timer;
    logic [VecSize-1:0]    pend;
    logic                  csr_enable;
    logic [11:0]           csr_addr;
    logic [31:0]           csr_out;
    logic [VecSize-1:0]    stamp_valid;

    int n_vec;
    int n_err;

    irq_stamp #(
        .VecSize    (VecSize),
        .TimerWidth (TimerWidth),
        .CsrBase    (CsrBase)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_mono_timer  (mono_timer),
        .i_pend        (pend),
        .i_csr_enable  (csr_enable),
        .i_csr_addr    (csr_addr),
        .o_csr_out     (csr_out),
        .o_stamp_valid (stamp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check(tag, csr_out, exp);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        pend       = '0;
        csr_enable = 1'b0;
        csr_addr   = CsrBase;
        mono_timer = '0;
        tick();
        tick();
        check("reset_csr", csr_out, 32'h0);
        check("reset_valid", 32'(stamp_valid), 32'h0);
        reset = 1'b0;

        // 1: idle with counting timer
        for (int t = 0; t < 3; t++) begin
            mono_timer = 16'(t);
            tick();
        end
        peek("idle_stamp0", CsrBase, 32'h0);
        peek("idle_status", CsrBase + 12'd8, 32'h0);
        check("idle_valid", 32'(stamp_valid), 32'h0);

        // 2: single capture and consuming read
        mono_timer = 16'd5;
        pend       = 8'h02;
        tick();
        csr_enable = 1'b1;
        peek("cap1_read", CsrBase + 12'd1, 32'h0000_0005);
        check("cap1_valid", 32'(stamp_valid), 32'h02);
        tick();
        csr_enable = 1'b0;
        check("cap1_cleared", 32'(stamp_valid), 32'h0);
        peek("cap1_status", CsrBase + 12'd8, 32'h0);
        pend = '0;
        tick();

        // 3: simultaneous rise plus an inter-edge glitch on vector 3
        mono_timer = 16'd11;
        pend       = 8'h06;
        tick();
        pend = 8'h0E;
        #1;
        pend = 8'h06;
        peek("multi_s1", CsrBase + 12'd1, 32'h0000_000B);
        peek("multi_s2", CsrBase + 12'd2, 32'h0000_000B);
        peek("glitch_s3", CsrBase + 12'd3, 32'h0);
        check("multi_valid", 32'(stamp_valid), 32'h06);
        pend       = '0;
        csr_enable = 1'b1;
        csr_addr   = CsrBase + 12'd1;
        tick();
        csr_addr = CsrBase + 12'd2;
        tick();
        csr_enable = 1'b0;
        check("multi_drained", 32'(stamp_valid), 32'h0);

        // 4: overrun on a second capture with no read in between
        mono_timer = 16'd20;
        pend       = 8'h10;
        tick();
        pend = '0;
        tick();
        mono_timer = 16'd30;
        pend       = 8'h10;
        tick();
        pend = '0;
        peek("ovr_stamp", CsrBase + 12'd4, 32'h8000_001E);
        peek("ovr_status", CsrBase + 12'd8, 32'h0010_0010);
        csr_enable = 1'b1;
        csr_addr   = CsrBase + 12'd4;
        tick();
        csr_enable = 1'b0;
        peek("ovr_after_read", CsrBase + 12'd4, 32'h0000_001E);
        peek("ovr_status_clr", CsrBase + 12'd8, 32'h0);

        // 5: read and capture on the same vector in the same cycle
        mono_timer = 16'd7;
        pend       = 8'h01;
        tick();
        pend = '0;
        tick();
        mono_timer = 16'd40;
        pend       = 8'h01;
        csr_enable = 1'b1;
        peek("rdcap_old", CsrBase, 32'h0000_0007);
        tick();
        csr_enable = 1'b0;
        peek("rdcap_new", CsrBase, 32'h0000_0028);
        check("rdcap_valid", 32'(stamp_valid), 32'h01);
        pend = '0;
        tick();

        // 6: pend held through reset, mid-run reset, unmapped addresses
        pend  = 8'h20;
        reset = 1'b1;
        tick();
        check("rst_valid", 32'(stamp_valid), 32'h0);
        peek("rst_stamp0", CsrBase, 32'h0);
        reset      = 1'b0;
        mono_timer = 16'd3;
        tick();
        peek("held_stamp5", CsrBase + 12'd5, 32'h0000_0003);
        check("held_valid", 32'(stamp_valid), 32'h20);
        reset = 1'b1;
        tick();
        pend  = '0;
        reset = 1'b0;
        check("midrst_valid", 32'(stamp_valid), 32'h0);
        peek("midrst_stamp5", CsrBase + 12'd5, 32'h0);
        peek("midrst_status", CsrBase + 12'd8, 32'h0);
        tick();
        mono_timer = 16'd9;
        pend       = 8'h01;
        tick();
        pend = '0;
        peek("post_stamp0", CsrBase, 32'h0000_0009);
        peek("unmapped_hi", CsrBase + 12'd9, 32'h0);
        peek("unmapped_lo", CsrBase - 12'd1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_stamp.md
Name: irq_stamp

Overview:
- Downstream consumer of the monotonic timer's count output.
- Latches the timer value on the rising edge of each interrupt pend line, giving per-vector arrival time stamps.
- Tracks valid and overrun status per vector.
- Exposes stamps and status as read-only CSRs to the core's CSR read path.

Parameters:
- VecSize, 8, number of interrupt vectors stamped (1..16).
- TimerWidth, 16, width of the incoming timer count (1..31).
- CsrBase, 12'hB40, CSR address of stamp[0]; stamp[k] at CsrBase+k; status at CsrBase+VecSize.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mono_timer  in  TimerWidth  current count from the monotonic timer.
- pend  in  VecSize  interrupt pend levels, one per vector.
- csr_enable  in  1  CSR access strobe for this cycle.
- csr_addr  in  12  CSR address.
- csr_out  out  32  read data for csr_addr, combinational.
- stamp_valid  out  VecSize  per-vector "unread capture present" flags.

Behaviour:
- One clock, clk. Synchronous active-high reset.
- Reset values: stamp[k]=0, valid[k]=0, overrun[k]=0, pend_q=0, stamp_valid=0.
  - csr_out is combinational from state, so it reads 0 at any address during reset.
  - pend_q is cleared, so a pend line held high through reset counts as an edge on the first post-reset clock.
- Edge detect: rise[k] = pend[k] & ~pend_q[k]; pend_q <= pend every clock.
  - Glitches between clock edges are ignored; pend is only sampled at rising clk.
- Capture, on the clock edge where rise[k]=1:
  - stamp[k] <= mono_timer sampled at that same edge, so the stamp equals the timer value visible before the edge. Latency: new value readable on csr_out one cycle after pend goes high.
  - If valid[k] was already 1 and no clearing read occurs this cycle: overrun[k] <= 1.
  - valid[k] <= 1.
- Multiple vectors may rise on the same edge; each captures the same mono_timer value independently.
- CSR decode:
  - addr CsrBase+k, k<VecSize: csr_out = {overrun[k], zero pad, stamp[k]} (stamp zero-extended into bits TimerWidth-1:0, bit 31 = overrun).
  - addr CsrBase+VecSize: csr_out = {overrun zero-extended to 16 bits, valid zero-extended to 16 bits}.
  - Any other address: csr_out = 0.
- Read side effect: csr_enable=1 at CsrBase+k clears valid[k] and overrun[k] at that clock edge.
  - Write data and op type are not inputs; writes have no effect.
  - The status register read has no side effect.
- Read and capture on the same vector in the same cycle:
  - The read returns the old stamp and old overrun (combinational).
  - At the edge the capture wins: stamp[k] updated, valid[k]=1, overrun[k]=0, since the old stamp was consumed.
- Timer wrap: mono_timer wrapping to 0 is captured verbatim; no wrap tracking in this block.
- Reset mid-operation: all flags and stamps clear at that edge; pending captures are dropped.
- stamp_valid = valid register, driven directly.

Test Plan:
1. Reset, then pend=0 for 3 clocks, bench timer counting from 0 by 1/clk -> csr_out at CsrBase = 0, status = 0, stamp_valid=0.
2. Raise pend[1] when mono_timer=5, read CsrBase+1 next cycle -> csr_out=5, bit31=0, stamp_valid[1]=1; after the read edge stamp_valid[1]=0 and status valid bit1=0.
3. Raise pend[1] (mono_timer=11) and pend[2] on the same edge -> both stamps read 11.
   - Glitch pend[3] high/low between edges -> stamp[3] unchanged, valid[3]=0.
4. Pulse pend[4] at mono_timer=20, drop it, pulse again at mono_timer=30 with no read between -> CsrBase+4 reads 30 with bit31=1 (0x8000001E); status bit 20 set; after the read, overrun and valid clear.
5. Pend[0] rising on the same cycle as csr_enable read of CsrBase+0 (old stamp 7, new timer 40) -> csr_out=7 that cycle; next cycle stamp=40, valid[0]=1, overrun[0]=0.
6. Hold pend[5] high through reset (timer=0x0003 on first post-reset edge) -> stamp[5]=3, valid[5]=1.
   - Assert reset mid-run with valid bits set -> all stamps, flags, and csr_out return to 0 next cycle.
   - Unmapped address CsrBase+VecSize+1 -> csr_out=0.
